// File: rtl/d_ff_debounce.sv
// d_ff_debounce: two-flop synchroniser plus counter-qualified debouncer with level and edge-pulse outputs
module d_ff_debounce #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int CNT_W = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_in,
  output logic q,
  output logic qb,
  output logic rise,
  output logic fall,
  output logic busy
);
  typedef enum logic [1:0] {STABLE_LO, PEND_HI, STABLE_HI, PEND_LO} state_t;
  localparam logic [CNT_W-1:0] LIM = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam bit ONE = DEBOUNCE_CYCLES == 1;
  state_t state, state_nx;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic s1, s2, q_nx, rise_nx, fall_nx;
  assign busy = state == PEND_HI || state == PEND_LO;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      state <= STABLE_LO;
      cnt <= '0;
      q <= 1'b0;
      qb <= 1'b1;
      rise <= 1'b0;
      fall <= 1'b0;
    end else begin
      s1 <= d_in;
      s2 <= s1;
      state <= state_nx;
      cnt <= cnt_nx;
      q <= q_nx;
      qb <= ~q_nx;
      rise <= rise_nx;
      fall <= fall_nx;
    end
  end
  // any disagreement with the candidate level aborts and clears the count
  always_comb begin
    state_nx = state;
    cnt_nx = cnt;
    q_nx = q;
    rise_nx = 1'b0;
    fall_nx = 1'b0;
    case (state)
      STABLE_LO:
        if (s2) begin
          if (ONE) begin
            state_nx = STABLE_HI;
            q_nx = 1'b1;
            rise_nx = 1'b1;
          end else begin
            state_nx = PEND_HI;
            cnt_nx = CNT_W'(1);
          end
        end
      PEND_HI:
        if (!s2) begin
          state_nx = STABLE_LO;
          cnt_nx = '0;
        end else if (cnt == LIM) begin
          state_nx = STABLE_HI;
          q_nx = 1'b1;
          rise_nx = 1'b1;
          cnt_nx = '0;
        end else cnt_nx = cnt + 1'b1;
      STABLE_HI:
        if (!s2) begin
          if (ONE) begin
            state_nx = STABLE_LO;
            q_nx = 1'b0;
            fall_nx = 1'b1;
          end else begin
            state_nx = PEND_LO;
            cnt_nx = CNT_W'(1);
          end
        end
      PEND_LO:
        if (s2) begin
          state_nx = STABLE_HI;
          cnt_nx = '0;
        end else if (cnt == LIM) begin
          state_nx = STABLE_LO;
          q_nx = 1'b0;
          fall_nx = 1'b1;
          cnt_nx = '0;
        end else cnt_nx = cnt + 1'b1;
    endcase
  end
endmodule
